write_back_stage: RTL and testbench
===================================

Name: write_back_stage

Overview:
- Final pipeline stage; the write side of the decode-stage register file.
- Takes the MEM/WB bundle, selects the result, and drives regWrite / Rdst / writeData back into the register file one cycle later.
- Also owns the 16-bit OUT port register.
- Sequences two-write SWAP instructions over two cycles and stalls upstream meanwhile.

Parameters:
- DATA_W, 16, datapath / register width
- REG_ADDR_W, 3, register index width (8 registers)

Ports:
- clk  in  1  stage clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- valid  in  1  MEM/WB bundle holds a live instruction
- flush  in  1  kill current bundle and any pending second write
- wbEn  in  1  instruction writes a register
- memToReg  in  1  1 = writeData from memData, 0 = from aluResult
- outEn  in  1  instruction is OUT; latch result onto outPort
- swapEn  in  1  instruction is SWAP (two register writes)
- wbRdst  in  REG_ADDR_W  first destination register
- wbRsrc  in  REG_ADDR_W  second destination (SWAP only)
- aluResult  in  DATA_W  ALU result (SWAP: value for wbRdst)
- memData  in  DATA_W  memory read data
- secondData  in  DATA_W  SWAP value for wbRsrc
- regWrite  out  1  register-file write enable
- Rdst  out  REG_ADDR_W  register-file write address
- writeData  out  DATA_W  register-file write data
- outPort  out  DATA_W  output port value
- stall  out  1  hold MEM/WB and earlier stages

Behaviour:
- Reset (rst=0, async):
  - regWrite=0, Rdst=0, writeData=0, outPort=0.
  - state=IDLE; the captured SWAP address and data are cleared to 0.
  - stall=0.
- Outputs regWrite/Rdst/writeData/outPort are registered: one cycle of latency from the sampled bundle.
- stall is combinational from state: 1 only in SWAP2.
- sel = memToReg ? memData : aluResult.
- State IDLE, at each posedge:
  - flush=1: regWrite<=0; stay IDLE.
  - valid&wbEn&!swapEn: regWrite<=1, Rdst<=wbRdst, writeData<=sel.
  - valid&wbEn&swapEn:
    - regWrite<=1, Rdst<=wbRdst, writeData<=aluResult (memToReg ignored).
    - Capture wbRsrc and secondData internally.
    - Go to SWAP2.
  - valid&outEn: outPort<=sel. May coincide with a register write; both take effect.
  - Otherwise: regWrite<=0. Rdst/writeData hold their last values (don't-care while regWrite=0).
- State SWAP2:
  - stall=1. All bundle inputs (valid etc.) are ignored; upstream is required to hold them.
  - Next posedge: regWrite<=1, Rdst<=captured wbRsrc, writeData<=captured secondData, go to IDLE.
  - flush=1 in SWAP2: regWrite<=0, second write dropped, go to IDLE.
- Result: a SWAP produces writes on two consecutive cycles and exactly one stall cycle.
- Priority: rst > flush > swap sequencing > normal write.
- swapEn with wbEn=0 is treated as no write and no SWAP2 entry.
- outEn with swapEn: outPort<=sel, SWAP proceeds normally.
- SWAP with wbRdst==wbRsrc: both writes still issue; the second wins (value = secondData).
- outPort holds its value indefinitely between OUT instructions; only reset clears it.
- Reset asserted mid-SWAP: return to IDLE, no second write, stall drops immediately (async).
- No arithmetic; all paths are width-exact DATA_W copies.

Decomposition:
- Shared pipeline package:
  - state enum {IDLE, SWAP2}
  - DATA_W and REG_ADDR_W constants
  - struct/bit-field layout of the MEM/WB bundle (wbEn, memToReg, outEn, swapEn positions in the control-signal vector)
- No sub-module; a single module with one FSM and output registers. Result mux inline.

Test Plan:
- Reset release, then valid=1, wbEn=1, memToReg=0, wbRdst=3, aluResult=0x1234 -> next cycle regWrite=1, Rdst=3, writeData=0x1234; following idle cycle regWrite=0.
- memToReg=1, memData=0xBEEF, aluResult=0x0001, wbRdst=5 -> writeData=0xBEEF, Rdst=5.
- SWAP: wbRdst=1, wbRsrc=2, aluResult=0x00AA, secondData=0x00BB ->
  - cycle+1: write R1=0x00AA, stall=1
  - cycle+2: write R2=0x00BB, stall=0
  - Bundle inputs changed during stall have no effect.
- OUT: outEn=1, wbEn=0, aluResult=0x5A5A -> outPort=0x5A5A, regWrite=0; outPort still 0x5A5A after 10 idle cycles.
- Flush in SWAP2 after first write of R4 -> no write to second register, stall drops, state IDLE. Separately, flush with a valid write in IDLE -> regWrite stays 0.
- rst pulled low asynchronously mid-SWAP2 -> all outputs 0 immediately; after release, a normal write to R7=0xFFFF completes with one-cycle latency.

Source files
------------

// File: rtl/write_back_stage_pkg.sv
// Shared write-back definitions: datapath widths, FSM state encoding and the
// layout of the control portion of the MEM/WB bundle.
package write_back_stage_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SWAP2 = 1'b1
    } wb_state_e;

    // Bit positions of the write-back controls within the packed control vector
    localparam int CTRL_WB_EN      = 3;
    localparam int CTRL_MEM_TO_REG = 2;
    localparam int CTRL_OUT_EN     = 1;
    localparam int CTRL_SWAP_EN    = 0;
    localparam int CTRL_W          = 4;

    typedef struct packed {
        logic wb_en;
        logic mem_to_reg;
        logic out_en;
        logic swap_en;
    } wb_ctrl_t;

    function automatic wb_ctrl_t pack_ctrl(
        input logic wb_en,
        input logic mem_to_reg,
        input logic out_en,
        input logic swap_en
    );
        logic [CTRL_W-1:0] vec;
        vec                  = '0;
        vec[CTRL_WB_EN]      = wb_en;
        vec[CTRL_MEM_TO_REG] = mem_to_reg;
        vec[CTRL_OUT_EN]     = out_en;
        vec[CTRL_SWAP_EN]    = swap_en;
        return wb_ctrl_t'(vec);
    endfunction

endpackage

// File: rtl/write_back_stage.sv
// Final pipeline stage: selects the result, drives the register-file write port
// one cycle later, owns the OUT port and sequences two-write SWAP instructions.
module write_back_stage
    import write_back_stage_pkg::wb_state_e;
    import write_back_stage_pkg::IDLE;
    import write_back_stage_pkg::SWAP2;
    import write_back_stage_pkg::wb_ctrl_t;
    import write_back_stage_pkg::pack_ctrl;
#(
    parameter int DATA_W     = write_back_stage_pkg::DATA_W,
    parameter int REG_ADDR_W = write_back_stage_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  flush,
    input  logic                  wbEn,
    input  logic                  memToReg,
    input  logic                  outEn,
    input  logic                  swapEn,
    input  logic [REG_ADDR_W-1:0] wbRdst,
    input  logic [REG_ADDR_W-1:0] wbRsrc,
    input  logic [DATA_W-1:0]     aluResult,
    input  logic [DATA_W-1:0]     memData,
    input  logic [DATA_W-1:0]     secondData,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] Rdst,
    output logic [DATA_W-1:0]     writeData,
    output logic [DATA_W-1:0]     outPort,
    output logic                  stall
);

    wb_ctrl_t              ctrl;
    logic [DATA_W-1:0]     sel;
    logic                  do_write;
    logic                  do_swap;
    logic                  do_out;

    wb_state_e             state_reg;
    logic                  reg_write_reg;
    logic [REG_ADDR_W-1:0] rdst_reg;
    logic [DATA_W-1:0]     write_data_reg;
    logic [DATA_W-1:0]     out_port_reg;
    logic [REG_ADDR_W-1:0] swap_addr_reg;
    logic [DATA_W-1:0]     swap_data_reg;

    assign ctrl     = pack_ctrl(wbEn, memToReg, outEn, swapEn);
    assign sel      = ctrl.mem_to_reg ? memData : aluResult;
    assign do_write = valid & ctrl.wb_en;
    assign do_swap  = do_write & ctrl.swap_en;
    assign do_out   = valid & ctrl.out_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            reg_write_reg  <= 1'b0;
            rdst_reg       <= '0;
            write_data_reg <= '0;
            out_port_reg   <= '0;
            swap_addr_reg  <= '0;
            swap_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (flush) begin
                        reg_write_reg <= 1'b0;
                    end else begin
                        if (do_write) begin
                            reg_write_reg  <= 1'b1;
                            rdst_reg       <= wbRdst;
                            // SWAP's first value always comes from the ALU
                            write_data_reg <= do_swap ? aluResult : sel;
                        end else begin
                            reg_write_reg  <= 1'b0;
                        end
                        if (do_swap) begin
                            swap_addr_reg <= wbRsrc;
                            swap_data_reg <= secondData;
                            state_reg     <= SWAP2;
                        end
                        if (do_out) begin
                            out_port_reg <= sel;
                        end
                    end
                end
                SWAP2: begin
                    // Bundle inputs are ignored here; upstream is held by stall
                    if (flush) begin
                        reg_write_reg  <= 1'b0;
                    end else begin
                        reg_write_reg  <= 1'b1;
                        rdst_reg       <= swap_addr_reg;
                        write_data_reg <= swap_data_reg;
                    end
                    state_reg <= IDLE;
                end
                default: begin
                    reg_write_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign regWrite  = reg_write_reg;
    assign Rdst      = rdst_reg;
    assign writeData = write_data_reg;
    assign outPort   = out_port_reg;
    assign stall     = (state_reg == SWAP2);

endmodule

// File: tb/tb_write_back_stage.sv
// Bench for write_back_stage: directed scenarios plus random traffic, checked
// against a queue-based model of pending register writes.
module tb_write_back_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0, flush = 1'b0, wbEn = 1'b0, memToReg = 1'b0;
    logic        outEn = 1'b0, swapEn = 1'b0;
    logic [2:0]  wbRdst = '0, wbRsrc = '0;
    logic [15:0] aluResult = '0, memData = '0, secondData = '0;
    logic        regWrite;
    logic [2:0]  Rdst;
    logic [15:0] writeData;
    logic [15:0] outPort;
    logic        stall;

    always #5 clk = ~clk;

    write_back_stage #(.DATA_W(16), .REG_ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .valid(valid), .flush(flush), .wbEn(wbEn),
        .memToReg(memToReg), .outEn(outEn), .swapEn(swapEn), .wbRdst(wbRdst),
        .wbRsrc(wbRsrc), .aluResult(aluResult), .memData(memData),
        .secondData(secondData), .regWrite(regWrite), .Rdst(Rdst),
        .writeData(writeData), .outPort(outPort), .stall(stall)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model: register writes still owed to the register file, in issue order
    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t         pend[$];
    logic        m_rw;
    logic [2:0]  m_rd;
    logic [15:0] m_wd;
    logic [15:0] m_out;
    logic [15:0] m_rf [8];
    logic [15:0] d_rf [8];

    task automatic model_reset();
        pend.delete();
        m_rw  = 1'b0;
        m_rd  = '0;
        m_wd  = '0;
        m_out = '0;
    endtask

    task automatic cycle(input logic v, input logic f, input logic we, input logic m2r,
                         input logic oe, input logic sw, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [15:0] alu,
                         input logic [15:0] md, input logic [15:0] sd);
        wr_t w;
        valid = v; flush = f; wbEn = we; memToReg = m2r; outEn = oe; swapEn = sw;
        wbRdst = rd; wbRsrc = rs; aluResult = alu; memData = md; secondData = sd;
        if (f) begin
            pend.delete();
            m_rw = 1'b0;
        end else if (pend.size() > 0) begin
            w    = pend.pop_front();
            m_rw = 1'b1;
            m_rd = w.a;
            m_wd = w.d;
        end else begin
            m_rw = 1'b0;
            if (v && we) begin
                m_rw = 1'b1;
                m_rd = rd;
                m_wd = sw ? alu : (m2r ? md : alu);
                if (sw) pend.push_back(wr_t'{rs, sd});
            end
            if (v && oe) m_out = m2r ? md : alu;
        end
        if (m_rw) m_rf[m_rd] = m_wd;
        @(posedge clk);
        #1;
        if (regWrite) d_rf[Rdst] = writeData;
        check("regWrite", {31'd0, regWrite}, {31'd0, m_rw});
        if (m_rw) begin
            check("Rdst", {29'd0, Rdst}, {29'd0, m_rd});
            check("writeData", {16'd0, writeData}, {16'd0, m_wd});
        end
        check("outPort", {16'd0, outPort}, {16'd0, m_out});
        check("stall", {31'd0, stall}, {31'd0, (pend.size() > 0)});
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_regWrite"}, {31'd0, regWrite}, 32'd0);
        check({tag, "_Rdst"}, {29'd0, Rdst}, 32'd0);
        check({tag, "_writeData"}, {16'd0, writeData}, 32'd0);
        check({tag, "_outPort"}, {16'd0, outPort}, 32'd0);
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_rf[i] = '0;
            d_rf[i] = '0;
        end
        model_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b1;

        // Plain ALU write, then idle
        cycle(1, 0, 1, 0, 0, 0, 3'd3, 3'd0, 16'h1234, 16'h0000, 16'h0000);
        cycle(0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        // Memory-sourced write
        cycle(1, 0, 1, 1, 0, 0, 3'd5, 3'd0, 16'h0001, 16'hBEEF, 16'h0000);
        // SWAP R1/R2, inputs altered during the stall cycle
        cycle(1, 0, 1, 0, 0, 1, 3'd1, 3'd2, 16'h00AA, 16'h0000, 16'h00BB);
        cycle(1, 0, 1, 1, 1, 1, 3'd6, 3'd7, 16'hDEAD, 16'hCAFE, 16'hF00D);
        cycle(0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        // OUT only, then ten idle cycles
        cycle(1, 0, 0, 0, 1, 0, 3'd0, 3'd0, 16'h5A5A, 16'h0000, 16'h0000);
        for (int i = 0; i < 10; i++)
            cycle(0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 16'h1111, 16'h2222, 16'h3333);
        // Flush during SWAP2 drops the second write
        cycle(1, 0, 1, 0, 0, 1, 3'd4, 3'd6, 16'h0044, 16'h0000, 16'h0066);
        cycle(1, 1, 1, 0, 0, 0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        cycle(0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        // Flush with a valid write (and OUT) in IDLE
        cycle(1, 1, 1, 0, 1, 0, 3'd2, 3'd0, 16'h7777, 16'h0000, 16'h0000);
        // SWAP with identical addresses, combined with OUT
        cycle(1, 0, 1, 1, 1, 1, 3'd3, 3'd3, 16'h0101, 16'h0202, 16'h0303);
        cycle(0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        // swapEn without wbEn: no write, no stall
        cycle(1, 0, 0, 0, 0, 1, 3'd1, 3'd2, 16'h9999, 16'h0000, 16'h8888);

        // Asynchronous reset in the middle of SWAP2
        cycle(1, 0, 1, 0, 0, 1, 3'd5, 3'd6, 16'h0055, 16'h0000, 16'h0066);
        #2;
        rst = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1, 0, 1, 0, 0, 0, 3'd7, 3'd0, 16'hFFFF, 16'h0000, 16'h0000);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  3'($urandom), 3'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom));
        end

        for (int i = 0; i < 8; i++)
            check($sformatf("regfile_r%0d", i), {16'd0, d_rf[i]}, {16'd0, m_rf[i]});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
